// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pattern_pkg;

  // Internal storage width for period/duty fields; the top-level PW must not exceed it.
  localparam int unsigned LED_PW_MAX = 32;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_BURST = 2'd3
  } led_mode_e;

  typedef struct packed {
    led_mode_e               mode;
    logic [LED_PW_MAX-1:0]   period;
    logic [LED_PW_MAX-1:0]   duty;
    logic [3:0]              burst;
  } led_cfg_t;

  localparam led_cfg_t LED_CFG_RESET = '{
    mode:   LED_OFF,
    period: {LED_PW_MAX{1'b0}},
    duty:   {LED_PW_MAX{1'b0}},
    burst:  4'd0
  };

  // Terminal count of the timebase prescaler (counts 0..terminal).
  function automatic int unsigned led_presc_tc(input int unsigned clk_hz,
                                               input int unsigned tick_hz);
    return (clk_hz / tick_hz) - 32'd1;
  endfunction

endpackage

// File: rtl/led_pattern_chan.sv
// One LED channel: shadow/active configuration, phase and burst counters,
// period-boundary apply logic and registered output decode.
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int unsigned PW         = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     tick,
  input  logic     wr_en,
  input  led_cfg_t wr_cfg,
  output logic     pending,
  output logic     led,
  output logic     wrap
);

  led_cfg_t        act_r;
  led_cfg_t        shd_r;
  led_cfg_t        act_nxt_s;
  led_cfg_t        shd_nxt_s;
  logic            pend_r;
  logic            pend_nxt_s;
  logic [PW-1:0]   phase_r;
  logic [PW-1:0]   phase_nxt_s;
  logic [3:0]      bcnt_r;
  logic [3:0]      bcnt_nxt_s;
  logic            led_r;
  logic            wrap_r;

  logic            per_zero_s;
  logic            at_end_s;
  logic            advance_s;
  logic            boundary_s;
  logic            static_mode_s;
  logic            apply_s;
  logic            nxt_per_zero_s;
  logic            on_phase_s;
  logic            led_nxt_s;

  // Counter advance, shadow capture and the decision of when pending data goes live
  always_comb begin
    act_nxt_s   = act_r;
    shd_nxt_s   = shd_r;
    pend_nxt_s  = pend_r;
    phase_nxt_s = phase_r;
    bcnt_nxt_s  = bcnt_r;

    per_zero_s = (act_r.period == {LED_PW_MAX{1'b0}});
    at_end_s   = (LED_PW_MAX'(phase_r) == (act_r.period - LED_PW_MAX'(1'b1)));
    advance_s  = tick && !per_zero_s;
    boundary_s = advance_s && at_end_s;

    case (act_r.mode)
      LED_OFF, LED_ON: static_mode_s = 1'b1;
      default:         static_mode_s = 1'b0;
    endcase

    // Steady modes take new data at once; patterned modes wait for a clean
    // period edge, or the next tick when the period is zero (no edge ever comes).
    if (!pend_r) begin
      apply_s = 1'b0;
    end else if (static_mode_s) begin
      apply_s = 1'b1;
    end else if (per_zero_s) begin
      apply_s = tick;
    end else begin
      apply_s = boundary_s;
    end

    if (apply_s) begin
      act_nxt_s   = shd_r;
      pend_nxt_s  = 1'b0;
      phase_nxt_s = {PW{1'b0}};
      bcnt_nxt_s  = 4'd0;
    end else if (advance_s) begin
      if (at_end_s) begin
        phase_nxt_s = {PW{1'b0}};
        if (bcnt_r == act_r.burst) begin
          bcnt_nxt_s = 4'd0;
        end else begin
          bcnt_nxt_s = bcnt_r + 4'd1;
        end
      end else begin
        phase_nxt_s = phase_r + PW'(1'b1);
      end
    end else begin
      phase_nxt_s = phase_r;
    end

    // The handshake only grants a write when nothing is pending, so capture
    // never collides with an apply.
    if (wr_en) begin
      shd_nxt_s  = wr_cfg;
      pend_nxt_s = 1'b1;
    end else begin
      shd_nxt_s  = shd_r;
    end
  end

  // Pattern decode from the post-update state so o_led follows o_tick by one clock
  always_comb begin
    led_nxt_s      = 1'b0;
    nxt_per_zero_s = (act_nxt_s.period == {LED_PW_MAX{1'b0}});
    on_phase_s     = (LED_PW_MAX'(phase_nxt_s) < act_nxt_s.duty);
    case (act_nxt_s.mode)
      LED_OFF:   led_nxt_s = 1'b0;
      LED_ON:    led_nxt_s = 1'b1;
      LED_BLINK: led_nxt_s = !nxt_per_zero_s && on_phase_s;
      LED_BURST: led_nxt_s = !nxt_per_zero_s && (bcnt_nxt_s != act_nxt_s.burst) && on_phase_s;
      default:   led_nxt_s = 1'b0;
    endcase
  end

  // Channel state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      act_r   <= LED_CFG_RESET;
      shd_r   <= LED_CFG_RESET;
      pend_r  <= 1'b0;
      phase_r <= {PW{1'b0}};
      bcnt_r  <= 4'd0;
      led_r   <= ACTIVE_LOW;
      wrap_r  <= 1'b0;
    end else begin
      act_r   <= act_nxt_s;
      shd_r   <= shd_nxt_s;
      pend_r  <= pend_nxt_s;
      phase_r <= phase_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      led_r   <= led_nxt_s ^ ACTIVE_LOW;
      wrap_r  <= boundary_s;
    end
  end

  assign pending = pend_r;
  assign led     = led_r;
  assign wrap    = wrap_r;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write
// port with per-channel back-pressure, and NUM_CH independent channels.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned TICK_HZ    = 1_000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PW         = 16,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CW-1:0]     cfg_chan,
  input  logic [1:0]        cfg_mode,
  input  logic [PW-1:0]     cfg_period,
  input  logic [PW-1:0]     cfg_duty,
  input  logic [3:0]        cfg_burst,
  output logic [NUM_CH-1:0] o_led,
  output logic [NUM_CH-1:0] o_wrap,
  output logic              o_tick
);

  localparam int unsigned    TC   = led_presc_tc(CLK_HZ, TICK_HZ);
  localparam int unsigned    PRW  = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [PRW-1:0] TC_W = PRW'(TC);

  logic [PRW-1:0]     presc_r;
  logic [PRW-1:0]     presc_nxt_s;
  logic               tick_r;
  logic [NUM_CH-1:0]  wr_en_s;
  logic [NUM_CH-1:0]  pend_s;
  logic [2**CW-1:0]   pend_pad_s;
  led_cfg_t           wr_cfg_s;

  // Prescaler next count: wraps after the terminal value
  always_comb begin
    if (presc_r == TC_W) begin
      presc_nxt_s = {PRW{1'b0}};
    end else begin
      presc_nxt_s = presc_r + PRW'(1'b1);
    end
  end

  // Prescaler register; the tick is registered so it is high exactly while the count sits at terminal
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r <= {PRW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_nxt_s;
      tick_r  <= (presc_nxt_s == TC_W);
    end
  end

  // Ready is busy only for an in-range channel holding pending data; padding reads as idle
  always_comb begin
    pend_pad_s               = {(2**CW){1'b0}};
    pend_pad_s[NUM_CH-1:0]   = pend_s;
    cfg_ready                = ~pend_pad_s[cfg_chan];
  end

  // Write decode: out-of-range channels match no enable and are dropped
  always_comb begin
    wr_cfg_s.mode   = led_mode_e'(cfg_mode);
    wr_cfg_s.period = LED_PW_MAX'(cfg_period);
    wr_cfg_s.duty   = LED_PW_MAX'(cfg_duty);
    wr_cfg_s.burst  = cfg_burst;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      wr_en_s[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
    led_pattern_chan #(
      .PW         (PW),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .tick    (tick_r),
      .wr_en   (wr_en_s[g]),
      .wr_cfg  (wr_cfg_s),
      .pending (pend_s[g]),
      .led     (o_led[g]),
      .wrap    (o_wrap[g])
    );
  end

  assign o_tick = tick_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a 4-channel active-high instance and a
// 3-channel active-low instance (for out-of-range channel writes).
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_valid2;
  logic [1:0]  cfg_chan;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic [3:0]  cfg_burst;
  logic        cfg_ready;
  logic        cfg_ready2;
  logic [3:0]  o_led;
  logic [3:0]  o_wrap;
  logic        o_tick;
  logic [2:0]  o_led2;
  logic [2:0]  o_wrap2;
  logic        o_tick2;

  always #5 clock = ~clock;

  led_pattern_gen #(.CLK_HZ(100), .TICK_HZ(10), .NUM_CH(4), .PW(16), .ACTIVE_LOW(1'b0)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_burst(cfg_burst), .o_led(o_led), .o_wrap(o_wrap), .o_tick(o_tick)
  );

  led_pattern_gen #(.CLK_HZ(100), .TICK_HZ(10), .NUM_CH(3), .PW(16), .ACTIVE_LOW(1'b1)) dut2 (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_burst(cfg_burst), .o_led(o_led2), .o_wrap(o_wrap2), .o_tick(o_tick2)
  );

  typedef struct packed { logic led; logic wrap; } exp_t;
  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       cur_led;
  logic [7:0] burst_pat;
  int         n;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic led, input logic wrap);
    exp_t e;
    e.led  = led;
    e.wrap = wrap;
    sb_q.push_back(e);
  endtask

  task automatic cfg_write(input bit to2, input logic [1:0] ch, input logic [1:0] mode,
                           input int per, input int duty, input int bur, input logic exp_ready);
    @(posedge clock); #1;
    cfg_chan   = ch;
    cfg_mode   = mode;
    cfg_period = 16'(per);
    cfg_duty   = 16'(duty);
    cfg_burst  = 4'(bur);
    if (to2) cfg_valid2 = 1'b1;
    else     cfg_valid  = 1'b1;
    @(negedge clock);
    if (to2) chk_eq("ready2", cfg_ready2, exp_ready);
    else     chk_eq("ready", cfg_ready, exp_ready);
    @(posedge clock); #1;
    cfg_valid  = 1'b0;
    cfg_valid2 = 1'b0;
  endtask

  // Called right after an accepted write to a channel in OFF/ON: old value one
  // more cycle, new value from the cycle after.
  task automatic apply_now(input int ch, input logic exp_led);
    @(negedge clock);
    chk_eq("pre_apply", o_led[ch], cur_led);
    @(negedge clock);
    chk_eq("apply", o_led[ch], exp_led);
    cur_led = exp_led;
  endtask

  // Pop one scoreboard entry per tick, compared one clock after o_tick; the LED
  // must hold and o_wrap stay low on every other cycle.
  task automatic run_ticks(input int ch, input int nt);
    exp_t e;
    int   guard;
    for (int t = 0; t < nt; t++) begin
      guard = 0;
      do begin
        @(negedge clock);
        guard++;
        chk_eq("hold_led", o_led[ch], cur_led);
        chk_eq("hold_wrap", o_wrap[ch], 1'b0);
      end while (!o_tick && guard < 20);
      chk_eq("tick_seen", o_tick, 1'b1);
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_eq("tick_led", o_led[ch], e.led);
        chk_eq("tick_wrap", o_wrap[ch], e.wrap);
        cur_led = e.led;
      end else begin
        chk_eq("sb_depth", sb_q.size(), 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_valid2 = 1'b0; cfg_chan = 2'd0;
    cfg_mode = 2'd0; cfg_period = 16'd0; cfg_duty = 16'd0; cfg_burst = 4'd0;
    burst_pat = 8'b0001_0101;
    cur_led = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_eq("rst_led", o_led, 4'h0);
    chk_eq("rst_wrap", o_wrap, 4'h0);
    chk_eq("rst_tick", o_tick, 1'b0);
    chk_eq("rst_ready", cfg_ready, 1'b1);
    chk_eq("rst_led2", o_led2, 3'b111);

    // Idle timebase: tick every 10 clocks, outputs quiet
    @(posedge clock); #1 reset = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!o_tick && n < 30);
    chk_eq("first_tick", n, 10);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clock); n++;
        chk_eq("idle_led", o_led, 4'h0);
        chk_eq("idle_wrap", o_wrap, 4'h0);
        chk_eq("idle_led2", o_led2, 3'b111);
      end while (!o_tick && n < 30);
      chk_eq("tick_period", n, 10);
    end

    // ch0 BLINK period=4 duty=1
    cfg_write(1'b0, 2'd0, LED_BLINK, 4, 1, 0, 1'b1);
    cur_led = 1'b0;
    apply_now(0, 1'b1);
    for (int k = 1; k <= 12; k++) push_exp((k % 4) == 0, (k % 4) == 0);
    run_ticks(0, 12);

    // ch1 BLINK 8/4, duty change to 2 mid-period, blocked second write
    cfg_write(1'b0, 2'd1, LED_BLINK, 8, 4, 0, 1'b1);
    cur_led = 1'b0;
    apply_now(1, 1'b1);
    for (int k = 1; k <= 2; k++) push_exp((k % 8) < 4, 1'b0);
    run_ticks(1, 2);
    cfg_write(1'b0, 2'd1, LED_BLINK, 8, 2, 0, 1'b1);
    #1 chk_eq("busy_ready", cfg_ready, 1'b0);
    cfg_chan = 2'd0;
    #1 chk_eq("other_ready", cfg_ready, 1'b1);
    cfg_write(1'b0, 2'd1, LED_BLINK, 8, 7, 0, 1'b0);
    for (int k = 3; k <= 7; k++) push_exp((k % 8) < 4, 1'b0);
    for (int k = 8; k <= 17; k++) push_exp((k % 8) < 2, (k % 8) == 0);
    run_ticks(1, 15);

    // ch2 BURST period=2 duty=1 burst=3, then burst=0
    cfg_write(1'b0, 2'd2, LED_BURST, 2, 1, 3, 1'b1);
    cur_led = 1'b0;
    apply_now(2, burst_pat[0]);
    for (int k = 1; k <= 16; k++) push_exp(burst_pat[k % 8], (k % 2) == 0);
    run_ticks(2, 16);
    cfg_write(1'b0, 2'd2, LED_BURST, 2, 1, 0, 1'b1);
    for (int k = 17; k <= 24; k++) push_exp(1'b0, (k % 2) == 0);
    run_ticks(2, 8);

    // ch3 edge cases: period 0, duty > period, ON -> OFF
    cfg_write(1'b0, 2'd3, LED_BLINK, 0, 1, 0, 1'b1);
    cur_led = 1'b0;
    apply_now(3, 1'b0);
    for (int k = 1; k <= 4; k++) push_exp(1'b0, 1'b0);
    run_ticks(3, 4);
    cfg_write(1'b0, 2'd3, LED_BLINK, 4, 5, 0, 1'b1);
    push_exp(1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) push_exp(1'b1, ((k - 1) % 4) == 0);
    run_ticks(3, 8);
    cfg_write(1'b0, 2'd3, LED_ON, 0, 0, 0, 1'b1);
    repeat (60) @(negedge clock);
    chk_eq("on_level", o_led[3], 1'b1);
    cfg_write(1'b0, 2'd3, LED_OFF, 0, 0, 0, 1'b1);
    cur_led = 1'b1;
    apply_now(3, 1'b0);

    // Out-of-range channel on the 3-channel active-low instance
    cfg_write(1'b1, 2'd3, LED_ON, 0, 0, 0, 1'b1);
    repeat (3) @(negedge clock);
    chk_eq("oor_led2", o_led2, 3'b111);
    for (int i = 0; i < 3; i++) begin
      cfg_chan = 2'(i);
      #1 chk_eq("oor_ready2", cfg_ready2, 1'b1);
    end
    cfg_write(1'b1, 2'd1, LED_ON, 0, 0, 0, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk_eq("on_led2", o_led2, 3'b101);

    // Reset mid-burst with a write still pending
    for (int i = 0; i < 4; i++) cfg_write(1'b0, 2'(i), LED_BURST, 2, 1, 3, 1'b1);
    repeat (120) @(negedge clock);
    cfg_write(1'b0, 2'd3, LED_BURST, 2, 1, 3, 1'b1);
    #1 chk_eq("pend_ready", cfg_ready, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_eq("mid_rst_led", o_led, 4'h0);
    chk_eq("mid_rst_wrap", o_wrap, 4'h0);
    chk_eq("mid_rst_tick", o_tick, 1'b0);
    chk_eq("mid_rst_led2", o_led2, 3'b111);
    for (int i = 0; i < 4; i++) begin
      cfg_chan = 2'(i);
      #1 chk_eq("mid_rst_ready", cfg_ready, 1'b1);
    end
    @(posedge clock); #1 reset = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!o_tick && n < 30);
    chk_eq("post_rst_tick", n, 10);
    chk_eq("post_rst_led", o_led, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel successor to the single-LED heartbeat. It drives NUM_CH indicator outputs, each independently set to OFF, ON, BLINK (programmable period/duty) or BURST (N blinks then one dark period). All timing runs on a shared prescaled tick. Configuration arrives over a valid/ready write port and is applied glitch-free at period boundaries. Sits at board top level, fed by housekeeping/status logic.

Parameters:
CLK_HZ, 12_000_000, input clock frequency in Hz
TICK_HZ, 1_000, timebase tick rate in Hz; CLK_HZ/TICK_HZ must be an integer >= 2
NUM_CH, 4, number of LED channels (1..16)
PW, 16, width of the period and duty fields, in ticks
ACTIVE_LOW, 0, 1 inverts o_led at the output register

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accepted this cycle when high with cfg_valid
cfg_chan  input  $clog2(NUM_CH) (min 1)  target channel
cfg_mode  input  2  0=OFF 1=ON 2=BLINK 3=BURST
cfg_period  input  PW  period in ticks
cfg_duty  input  PW  on-time in ticks
cfg_burst  input  4  blinks per burst
o_led  output  NUM_CH  LED drive, registered
o_wrap  output  NUM_CH  one-cycle pulse per channel at each period boundary
o_tick  output  1  one-cycle timebase pulse

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: o_led all inactive (0, or all 1 when ACTIVE_LOW=1), o_wrap=0, o_tick=0. All channels go to mode OFF, period=0, duty=0, burst=0, with no update pending. Prescaler and phase counters clear. Reset mid-pattern aborts immediately.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and wraps. o_tick is high for the single cycle in which the count equals the terminal value.
- Per channel: active registers (mode/period/duty/burst), shadow registers plus a pending flag, phase counter (PW bits), burst counter (4 bits).
- Config handshake: cfg_ready = !pending[cfg_chan]. It is combinational on cfg_chan and independent of cfg_valid.
  - Transfer occurs when cfg_valid && cfg_ready: the shadow is loaded and pending is set.
  - cfg_chan >= NUM_CH: cfg_ready=1 and the write is discarded.
- Apply rule: pending data copies to active, and pending clears:
  - one cycle after the transfer, if the active mode is OFF or ON;
  - otherwise on the cycle of that channel's period boundary.
  - The phase counter and burst counter reset to 0 on apply.
  - Writing the same values still produces an apply/restart.
- Phase advance: on o_tick, phase = (phase == period-1) ? 0 : phase+1. Boundary means phase wraps to 0; o_wrap pulses that cycle.
- Output function, computed from state after the tick and registered (o_led changes exactly one clock after o_tick):
  - OFF: 0. ON: 1.
  - BLINK: phase < duty.
  - BURST: a cycle is burst+1 periods; during periods 0..burst-1 output is phase < duty; during period burst output is 0. The burst counter increments at each boundary and wraps after burst.
- Edge cases:
  - period=0 in BLINK/BURST: output 0, no boundary, no o_wrap. Pending applies on the next o_tick instead.
  - duty >= period: constant 1 within blink periods.
  - duty=0: constant 0.
  - burst=0: BURST outputs constant 0, but boundaries still occur.
- Channels are fully independent; simultaneous boundaries on several channels are legal.

Decomposition:
- Package led_pattern_pkg: mode enum (LED_OFF, LED_ON, LED_BLINK, LED_BURST), per-channel config struct (mode, period, duty, burst), and a function computing prescaler terminal count from CLK_HZ/TICK_HZ.
- Sub-module led_pattern_chan: one channel (shadow/active registers, pending flag, counters, output decode). Instantiated NUM_CH times via generate.
- Prescaler stays in the top.

Test Plan:
1. CLK_HZ=100, TICK_HZ=10, reset released, no writes -> o_tick every 10 clocks; o_led=0 and o_wrap=0 indefinitely.
2. Write ch0 BLINK period=4 duty=1 -> ch0 high 1 tick, low 3 ticks, repeating. o_wrap[0] pulses every 40 clocks. o_led edges lag o_tick by exactly 1 clock.
3. While ch1 runs BLINK period=8 duty=4, write duty=2, then attempt a second write before the boundary:
   - cfg_ready is low for ch1 and high for ch0;
   - the new duty takes effect only after the phase wraps;
   - no runt pulse appears mid-period.
4. ch2 BURST period=2 duty=1 burst=3 -> pattern over 8 ticks is 1,0,1,0,1,0,0,0 and repeats. burst=0 gives constant 0 with o_wrap still pulsing.
5. Edge cases:
   - ch3 BLINK period=0 -> output 0.
   - duty=5 period=4 -> constant 1.
   - ON -> OFF write takes effect 1 cycle after the transfer.
   - cfg_chan=NUM_CH write is ignored, with cfg_ready=1.
6. Assert reset mid-burst on all channels -> next cycle all o_led inactive and cfg_ready=1. With ACTIVE_LOW=1, inactive reads as 1.
